ring_rr_arbiter: RTL and testbench



---
 rtl/ring_rr_arbiter.sv | 115 +++++++++++
 tb/tb_ring_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring.
// Grants are single-owner, timeout-bounded, and the ring is seedable.
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] rel,
  input  logic         seed_load,
  input  logic [N-1:0] seed,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic         timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] PTR_RST = N'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  if (N < 2) begin : g_chk_n
    $error("ring_rr_arbiter: N must be at least 2");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_chk_hold
    $error("ring_rr_arbiter: MAX_HOLD out of range");
  end
  if ((64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_chk_cnt
    $error("ring_rr_arbiter: CNT_W too narrow");
  end

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_ptr;
  logic [N-1:0]     r_gnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_timeout;

  logic [IW-1:0]    w_pidx;
  logic [N-1:0]     w_rot;
  logic [N-1:0]     w_pick;
  logic [N-1:0]     w_win;
  logic [N-1:0]     w_next_ptr;
  logic             w_seed_ok;
  logic             w_rel;
  logic             w_hold_end;

  always_comb begin
    w_pidx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_ptr[i]) w_pidx = IW'(i);
    end
  end

  // Rotate req so the pointer lands on bit 0, pick lowest, rotate back.
  always_comb begin
    w_rot  = N'({req, req} >> w_pidx);
    w_pick = w_rot & (~w_rot + 1'b1);
    w_win  = N'(({w_pick, w_pick} << w_pidx) >> N);
  end

  assign w_seed_ok  = (seed != '0) &&
                      ((seed & (seed - 1'b1)) == '0);
  assign w_next_ptr = {r_gnt[N-2:0], r_gnt[N-1]};
  assign w_rel      = (|(r_gnt & rel)) || !(|(r_gnt & req));
  assign w_hold_end = (r_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= PTR_RST;
      r_gnt     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (seed_load) begin
            r_ptr <= w_seed_ok ? seed : PTR_RST;
          end else if (|req) begin
            r_gnt   <= w_win;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Release beats timeout when both land together.
          if (w_rel || w_hold_end) begin
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= w_next_ptr;
            r_timeout <= !w_rel;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: directed scenarios plus random traffic
// checked every cycle against an index-level reference model.
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] rel = '0;
  logic         seed_load = 1'b0;
  logic [N-1:0] seed = '0;
  logic [N-1:0] gnt;
  logic         busy;
  logic         timeout;

  int n_pass  = 0;
  int n_total = 0;

  ring_rr_arbiter #(
    .N(N),
    .MAX_HOLD(MAX_HOLD),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .rel(rel),
    .seed_load(seed_load),
    .seed(seed),
    .gnt(gnt),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: priority position, owner index, cycles held.
  int m_ptr   = 0;
  int m_owner = 0;
  int m_held  = 0;
  bit m_grant = 0;
  bit m_to    = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_ptr = 0; m_owner = 0; m_held = 0;
        m_grant = 0; m_to = 0;
      end else begin
        m_to = 0;
        if (!m_grant) begin
          if (seed_load) begin
            m_ptr = 0;
            if ($countones(seed) == 1)
              for (int i = 0; i < N; i++)
                if (seed[i]) m_ptr = i;
          end else if (req != 0) begin
            for (int k = N - 1; k >= 0; k--)
              if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            m_grant = 1;
            m_held  = 1;
          end
        end else begin
          if (rel[m_owner] || !req[m_owner]) begin
            m_grant = 0;
            m_ptr   = (m_owner + 1) % N;
          end else if (m_held == MAX_HOLD) begin
            m_grant = 0;
            m_ptr   = (m_owner + 1) % N;
            m_to    = 1;
          end else begin
            m_held++;
          end
        end
      end
    end
  end

  // Compare process: every negedge, DUT vs model and invariants.
  int run_len = 0;
  initial begin
    logic [N-1:0] exp_g;
    forever begin
      @(negedge clk);
      exp_g = m_grant ? N'(1 << m_owner) : '0;
      chk("gnt", 32'(gnt), 32'(exp_g));
      chk("busy", 32'(busy), 32'(m_grant));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("gnt_onehot0", 32'($countones(gnt) <= 1), 32'(1));
      if (gnt != 0) begin
        run_len++;
        chk("hold_bound", 32'(run_len <= MAX_HOLD), 32'(1));
      end else begin
        run_len = 0;
      end
    end
  end

  initial begin
    // Reset and first grant
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_to", 32'(timeout), 32'h0);
    reset = 1'b1; req = 4'b1111;
    tick(); chk("first_gnt", 32'(gnt), 32'h1);
    rel = 4'b0001;
    tick(); chk("first_gap", 32'(gnt), 32'h0);
    rel = '0;
    tick(); chk("second_gnt", 32'(gnt), 32'h2);

    // Fairness sweep
    for (int i = 1; i <= 4; i++) begin
      rel = N'(1 << (i % N));
      tick(); chk("fair_gap", 32'(gnt), 32'h0);
      rel = '0;
      tick(); chk("fair_gnt", 32'(gnt), 32'(1 << ((i + 1) % N)));
    end
    rel = 4'b0010; req = '0;
    tick(); rel = '0;
    tick();

    // Timeout
    req = 4'b0100;
    tick(); chk("to_gnt1", 32'(gnt), 32'h4);
    for (int i = 2; i <= MAX_HOLD; i++) begin
      tick();
      chk("to_hold", 32'(gnt), 32'h4);
      chk("to_hold_pulse", 32'(timeout), 32'h0);
    end
    tick();
    chk("to_gnt_off", 32'(gnt), 32'h0);
    chk("to_pulse", 32'(timeout), 32'h1);
    tick();
    chk("to_regnt", 32'(gnt), 32'h4);
    chk("to_pulse_end", 32'(timeout), 32'h0);
    req = '0;
    tick(); tick();

    // Seed load
    seed_load = 1'b1; seed = 4'b0001;
    tick();
    seed = 4'b1000; req = 4'b1001;
    tick(); chk("seed_nogrant", 32'(gnt), 32'h0);
    seed_load = 1'b0;
    tick(); chk("seed_gnt", 32'(gnt), 32'h8);
    req = '0;
    tick();
    seed_load = 1'b1; seed = 4'b0100;
    tick();
    seed = 4'b0101;
    tick();
    seed_load = 1'b0; req = 4'b1111;
    tick(); chk("bad_seed_gnt", 32'(gnt), 32'h1);

    // Non-owner release, owner drop
    rel = 4'b0001;
    tick(); rel = '0;
    tick(); chk("owner1", 32'(gnt), 32'h2);
    rel = 4'b0100;
    tick(); chk("nonowner_rel", 32'(gnt), 32'h2);
    rel = '0; req = 4'b1101;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h0);
    chk("drop_to", 32'(timeout), 32'h0);
    req = '0;
    tick();

    // Async reset mid-grant, then a fresh hold budget
    req = 4'b0010;
    tick(); chk("mid_gnt", 32'(gnt), 32'h2);
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    tick(); reset = 1'b1;
    tick(); chk("post_rst_gnt", 32'(gnt), 32'h2);
    repeat (MAX_HOLD - 1) begin
      tick(); chk("post_rst_hold", 32'(gnt), 32'h2);
    end
    tick(); chk("post_rst_to", 32'(timeout), 32'h1);
    req = '0;
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) req = N'($urandom);
      rel = ($urandom_range(0, 11) == 0) ? N'($urandom) : '0;
      seed_load = ($urandom_range(0, 15) == 0);
      seed = $urandom_range(0, 1) ? N'(1 << $urandom_range(0, N - 1))
                                  : N'($urandom);
    end
    reset = 1'b1; req = '0; rel = '0; seed_load = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
